// File: rtl/mpf_services_gen_csr_mux_if.sv
`default_nettype none
// ============================================================================
// mpf_services_gen_csr_mux_if : MMIO request/response bundle for the CSR mux
// Rev 1.0
// ============================================================================
interface mpf_services_gen_csr_mux_if #(
  parameter int ADDR_BITS = 16,
  parameter int TID_BITS  = 9
) ();
  logic                 mmio_rd_valid;
  logic                 mmio_wr_valid;
  logic [ADDR_BITS-1:0] mmio_addr;
  logic [TID_BITS-1:0]  mmio_tid;
  logic [63:0]          mmio_wr_data;
  logic                 mmio_rd_claimed;
  logic                 mmio_rsp_valid;
  logic [TID_BITS-1:0]  mmio_rsp_tid;
  logic [63:0]          mmio_rsp_data;

  modport master (
    output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wr_data,
    input  mmio_rd_claimed, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
  );

  modport slave (
    input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wr_data,
    output mmio_rd_claimed, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/mpf_services_gen_csr_mux.sv
`default_nettype none
// ============================================================================
// mpf_services_gen_csr_mux : shares an MMIO window among MPF CSR slaves and
// returns their read data in order; DFH generation enabled by MPF_GEN_CSR_MUX_DFH_EN
// Rev 1.0
// ============================================================================
module mpf_services_gen_csr_mux #(
  parameter int                    N_SLAVES     = 4,
  parameter int                    N_ENTRIES    = 16,
  parameter int                    BASE_IDX     = 0,
  parameter int                    ADDR_BITS    = 16,
  parameter int                    TID_BITS     = 9,
  parameter logic [12*N_SLAVES-1:0] FEATURE_IDS = '0,
  parameter bit                    LAST_IN_LIST = 1'b1
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  mpf_services_gen_csr_mux_if.slave          mmio,
  output logic [$clog2(N_ENTRIES)-1:0]       csr_req_idx,
  output logic [N_SLAVES-1:0]                csr_rd_req_en,
  output logic [N_SLAVES-1:0]                csr_wr_req_en,
  output logic [63:0]                        csr_wr_data,
  output logic [64*N_SLAVES-1:0]             csr_dfh_value,
  input  wire logic [N_SLAVES-1:0]           csr_rd_rsp_valid,
  input  wire logic [64*N_SLAVES-1:0]        csr_rd_data,
  output logic [7:0]                         rsp_err_cnt,
  output logic                               proto_err
);

  localparam int IDX_BITS = $clog2(N_ENTRIES);
  localparam int SLV_BITS = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(BASE_IDX);
  localparam logic [ADDR_BITS:0]   WINDOW_A = (ADDR_BITS+1)'(N_SLAVES * N_ENTRIES);

  logic [ADDR_BITS-1:0] offset;
  logic                 hit;

  // Window is N_ENTRIES-aligned, so slave/index are plain bit fields of the offset.
  assign offset = mmio.mmio_addr - BASE_A;
  assign hit    = (mmio.mmio_addr >= BASE_A) && ({1'b0, offset} < WINDOW_A);

  logic                s1_rd, s1_wr;
  logic [SLV_BITS-1:0] s1_slave;
  logic [IDX_BITS-1:0] s1_idx;
  logic [TID_BITS-1:0] s1_tid;
  logic [63:0]         s1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rd     <= 1'b0;
      s1_wr     <= 1'b0;
      s1_slave  <= '0;
      s1_idx    <= '0;
      s1_tid    <= '0;
      s1_data   <= '0;
      proto_err <= 1'b0;
    end else begin
      s1_rd    <= mmio.mmio_rd_valid & hit;
      s1_wr    <= mmio.mmio_wr_valid & ~mmio.mmio_rd_valid & hit;
      s1_slave <= offset[IDX_BITS +: SLV_BITS];
      s1_idx   <= offset[IDX_BITS-1:0];
      s1_tid   <= mmio.mmio_tid;
      s1_data  <= mmio.mmio_wr_data;
      if (mmio.mmio_rd_valid && mmio.mmio_wr_valid) begin
        proto_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_strobe
    assign csr_rd_req_en[i] = s1_rd && (s1_slave == SLV_BITS'(i));
    assign csr_wr_req_en[i] = s1_wr && (s1_slave == SLV_BITS'(i));
  end

  assign csr_req_idx          = s1_idx;
  assign csr_wr_data          = s1_data;
  assign mmio.mmio_rd_claimed = s1_rd;

  logic                s2_valid;
  logic [SLV_BITS-1:0] s2_slave;
  logic [TID_BITS-1:0] s2_tid;
  logic                sel_valid;
  logic [63:0]         sel_data;
  logic                out_valid;
  logic [TID_BITS-1:0] out_tid;
  logic [63:0]         out_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s2_slave == SLV_BITS'(i)) begin
        sel_valid = csr_rd_rsp_valid[i];
        sel_data  = csr_rd_data[64*i +: 64];
      end
    end
  end

  // s2 tracks the read whose slave answers this cycle; the result lands in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_slave    <= '0;
      s2_tid      <= '0;
      out_valid   <= 1'b0;
      out_tid     <= '0;
      out_data    <= '0;
      rsp_err_cnt <= '0;
    end else begin
      s2_valid  <= s1_rd;
      s2_slave  <= s1_slave;
      s2_tid    <= s1_tid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_tid  <= s2_tid;
        out_data <= sel_valid ? sel_data : 64'd0;
        if (!sel_valid && (rsp_err_cnt != 8'hFF)) begin
          rsp_err_cnt <= rsp_err_cnt + 8'd1;
        end
      end
    end
  end

  assign mmio.mmio_rsp_valid = out_valid;
  assign mmio.mmio_rsp_tid   = out_tid;
  assign mmio.mmio_rsp_data  = out_data;

`ifdef MPF_GEN_CSR_MUX_DFH_EN
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_dfh
    localparam logic EOL = 1'(LAST_IN_LIST && (i == N_SLAVES - 1));
    assign csr_dfh_value[64*i +: 64] = {4'h2, 19'd0, EOL,
                                        EOL ? 24'd0 : 24'(N_ENTRIES * 8),
                                        4'h0, FEATURE_IDS[12*i +: 12]};
  end
`else
  assign csr_dfh_value = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpf_services_gen_csr_mux.sv
`default_nettype none
// ============================================================================
// tb_mpf_services_gen_csr_mux : directed bench with response scoreboard
// Rev 1.0
// ============================================================================
module tb_mpf_services_gen_csr_mux;
  localparam int NS = 2;
  localparam int NE = 16;
  localparam int BASE = 32;
  localparam int AB = 16;
  localparam int TB = 9;
  localparam logic [23:0] FIDS = {12'h0B2, 12'h0A1};
`ifdef MPF_GEN_CSR_MUX_DFH_EN
  localparam logic [63:0] DFH0 = 64'h2000_0000_0080_00A1;
  localparam logic [63:0] DFH1 = 64'h2000_0100_0000_00B2;
`else
  localparam logic [63:0] DFH0 = 64'd0;
  localparam logic [63:0] DFH1 = 64'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpf_services_gen_csr_mux_if #(.ADDR_BITS(AB), .TID_BITS(TB)) mmio ();

  logic [3:0]   csr_req_idx;
  logic [1:0]   csr_rd_req_en, csr_wr_req_en;
  logic [63:0]  csr_wr_data;
  logic [127:0] csr_dfh_value;
  logic [1:0]   csr_rd_rsp_valid;
  logic [127:0] csr_rd_data;
  logic [7:0]   rsp_err_cnt;
  logic         proto_err;

  mpf_services_gen_csr_mux #(
    .N_SLAVES(NS), .N_ENTRIES(NE), .BASE_IDX(BASE), .ADDR_BITS(AB),
    .TID_BITS(TB), .FEATURE_IDS(FIDS), .LAST_IN_LIST(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .mmio(mmio),
    .csr_req_idx(csr_req_idx), .csr_rd_req_en(csr_rd_req_en),
    .csr_wr_req_en(csr_wr_req_en), .csr_wr_data(csr_wr_data),
    .csr_dfh_value(csr_dfh_value), .csr_rd_rsp_valid(csr_rd_rsp_valid),
    .csr_rd_data(csr_rd_data), .rsp_err_cnt(rsp_err_cnt), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [1:0] drop = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int s, input logic [3:0] idx);
    return {16'hC5A0, 8'(s), 4'h0, idx, 32'h0BAD_F00D ^ 32'(s * 7)};
  endfunction

  // Slave model: answers one cycle after its strobe, entry 0 returns its DFH.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      csr_rd_rsp_valid[s] <= reset ? 1'b0 : (csr_rd_req_en[s] & ~drop[s]);
      csr_rd_data[64*s +: 64] <= (csr_req_idx == 4'd0) ? csr_dfh_value[64*s +: 64]
                                                       : pat(s, csr_req_idx);
    end
  end

  typedef struct {
    logic [TB-1:0] tid;
    logic [63:0]   data;
    int            cyc;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (mmio.mmio_rsp_valid === 1'b1) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed tid=%0h data=%0h expected no response",
               mmio.mmio_rsp_tid, mmio.mmio_rsp_data);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        assert ({mmio.mmio_rsp_tid, mmio.mmio_rsp_data, cyc} === {e.tid, e.data, e.cyc}) else begin
          errors++;
          $error("FAIL rsp observed tid=%0h data=%0h cyc=%0d expected tid=%0h data=%0h cyc=%0d",
                 mmio.mmio_rsp_tid, mmio.mmio_rsp_data, cyc, e.tid, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rd(input logic [15:0] a, input logic [TB-1:0] t);
    exp_t e;
    int off, s;
    mmio.mmio_rd_valid = 1'b1;
    mmio.mmio_addr = a;
    mmio.mmio_tid = t;
    if (a >= 16'(BASE) && a < 16'(BASE + NS * NE)) begin
      off = int'(a) - BASE;
      s = off / NE;
      e.tid = t;
      e.cyc = cyc + 3;
      if (drop[s]) e.data = 64'd0;
      else if ((off % NE) == 0) e.data = (s == 0) ? DFH0 : DFH1;
      else e.data = pat(s, 4'(off % NE));
      sbq.push_back(e);
    end
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic [63:0] d);
    mmio.mmio_wr_valid = 1'b1;
    mmio.mmio_addr = a;
    mmio.mmio_wr_data = d;
  endtask

  task automatic idle();
    mmio.mmio_rd_valid = 1'b0;
    mmio.mmio_wr_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mmio.mmio_rd_valid = 1'b0;
    mmio.mmio_wr_valid = 1'b0;
    mmio.mmio_addr = '0;
    mmio.mmio_tid = '0;
    mmio.mmio_wr_data = '0;
    ticks(3);
    chk("reset_rd_en", 64'(csr_rd_req_en), 64'd0);
    chk("reset_wr_en", 64'(csr_wr_req_en), 64'd0);
    chk("reset_rsp_valid", 64'(mmio.mmio_rsp_valid), 64'd0);
    chk("reset_claimed", 64'(mmio.mmio_rd_claimed), 64'd0);
    chk("reset_proto_err", 64'(proto_err), 64'd0);
    chk("reset_err_cnt", 64'(rsp_err_cnt), 64'd0);
    chk("reset_rsp_data", mmio.mmio_rsp_data, 64'd0);
    chk("reset_rsp_tid", 64'(mmio.mmio_rsp_tid), 64'd0);
    chk("dfh0", csr_dfh_value[63:0], DFH0);
    chk("dfh1", csr_dfh_value[127:64], DFH1);
    // A read presented while reset is high must be ignored.
    mmio.mmio_rd_valid = 1'b1;
    mmio.mmio_addr = 16'h21;
    ticks(1);
    idle();
    reset = 1'b0;
    ticks(1);
    chk("reset_req_ignored", 64'(csr_rd_req_en), 64'd0);

    // DFH reads
    drive_rd(16'h20, 9'd5);
    ticks(1);
    chk("dfh_rd_claimed", 64'(mmio.mmio_rd_claimed), 64'd1);
    chk("dfh_rd_en", 64'(csr_rd_req_en), 64'b01);
    drive_rd(16'h30, 9'd6);
    ticks(1);
    chk("dfh_rd1_en", 64'(csr_rd_req_en), 64'b10);
    idle();
    ticks(4);

    // Routing
    drive_wr(16'h25, 64'hDEAD);
    ticks(1);
    chk("wr_en", 64'(csr_wr_req_en), 64'b01);
    chk("wr_idx", 64'(csr_req_idx), 64'd5);
    chk("wr_data", csr_wr_data, 64'hDEAD);
    chk("wr_claimed", 64'(mmio.mmio_rd_claimed), 64'd0);
    idle();
    drive_rd(16'h31, 9'd7);
    ticks(1);
    chk("rd_route_en", 64'(csr_rd_req_en), 64'b10);
    chk("rd_route_idx", 64'(csr_req_idx), 64'd1);
    chk("rd_route_wr_en", 64'(csr_wr_req_en), 64'd0);
    // Read then write of the same CSR reach the slave in order.
    drive_rd(16'h24, 9'd8);
    ticks(1);
    chk("rw_order_rd", 64'({csr_rd_req_en, csr_wr_req_en, csr_req_idx}), 64'({2'b01, 2'b00, 4'd4}));
    idle();
    drive_wr(16'h24, 64'h55);
    ticks(1);
    chk("rw_order_wr", 64'({csr_rd_req_en, csr_wr_req_en, csr_req_idx}), 64'({2'b00, 2'b01, 4'd4}));
    idle();
    ticks(4);

    // Misses
    drive_rd(16'h40, 9'd9);
    ticks(1);
    chk("miss_hi_en", 64'(csr_rd_req_en), 64'd0);
    chk("miss_hi_claimed", 64'(mmio.mmio_rd_claimed), 64'd0);
    drive_rd(16'h1F, 9'd10);
    ticks(1);
    chk("miss_lo_en", 64'(csr_rd_req_en), 64'd0);
    chk("miss_lo_claimed", 64'(mmio.mmio_rd_claimed), 64'd0);
    idle();
    drive_wr(16'h40, 64'h1);
    ticks(1);
    chk("miss_wr_en", 64'(csr_wr_req_en), 64'd0);
    idle();
    ticks(5);

    // Missing slave response and saturation
    drop = 2'b10;
    drive_rd(16'h33, 9'd11);
    ticks(1);
    idle();
    ticks(4);
    chk("err_cnt_1", 64'(rsp_err_cnt), 64'd1);
    for (int i = 0; i < 299; i++) begin
      drive_rd(16'h33, TB'(i));
      ticks(1);
    end
    idle();
    ticks(5);
    chk("err_cnt_sat", 64'(rsp_err_cnt), 64'd255);
    drop = 2'b00;

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive_rd(16'(16'h21 + i), TB'(i));
      ticks(1);
    end
    idle();
    ticks(5);

    // Simultaneous read and write
    chk("proto_err_pre", 64'(proto_err), 64'd0);
    drive_rd(16'h22, 9'h1AA);
    mmio.mmio_wr_valid = 1'b1;
    mmio.mmio_wr_data = 64'hBEEF;
    ticks(1);
    idle();
    chk("rdwr_wr_en", 64'(csr_wr_req_en), 64'd0);
    chk("rdwr_rd_en", 64'(csr_rd_req_en), 64'b01);
    chk("rdwr_proto_err", 64'(proto_err), 64'd1);
    ticks(5);

    // Reset mid-flight
    drive_rd(16'h21, 9'd1);
    ticks(1);
    drive_rd(16'h31, 9'd2);
    ticks(1);
    idle();
    reset = 1'b1;
    sbq.delete();
    ticks(2);
    reset = 1'b0;
    ticks(6);
    chk("rst_mid_err_cnt", 64'(rsp_err_cnt), 64'd0);
    chk("rst_mid_proto_err", 64'(proto_err), 64'd0);
    chk("rst_mid_rsp", {mmio.mmio_rsp_data[62:0], mmio.mmio_rsp_valid}, 64'd0);
    chk("rst_mid_tid", 64'(mmio.mmio_rsp_tid), 64'd0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) ticks(1);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
